// File: rtl/equiv_harness_ctrl_if.sv
// Bundle of the run-control, stimulus and compare signals between the
// equivalence-harness controller (master) and the driver of the design copies (slave).
interface equiv_harness_ctrl_if #(
    parameter int Y_W    = 421,
    parameter int STIM_W = 63
);
    logic              start;
    logic [15:0]       cycles;
    logic [31:0]       seed;
    logic [STIM_W-1:0] stim;
    logic [Y_W-1:0]    y_a;
    logic [Y_W-1:0]    y_b;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       mismatch_count;
    logic [15:0]       first_cycle;
    logic [8:0]        first_bit;

    modport master (
        input  start, cycles, seed, y_a, y_b,
        output stim, busy, done, pass, mismatch_count, first_cycle, first_bit
    );

    modport slave (
        output start, cycles, seed, y_a, y_b,
        input  stim, busy, done, pass, mismatch_count, first_cycle, first_bit
    );
endinterface

// File: rtl/equiv_harness_ctrl.sv
// Equivalence-check controller: drives LFSR stimulus to two design copies,
// compares their outputs every RUN/DRAIN cycle and reports the first mismatch.
module equiv_harness_ctrl #(
    parameter int Y_W       = 421,
    parameter int STIM_W    = 63,
    parameter int DRAIN_CYC = 2
) (
    input logic                  clk,
    input logic                  rst,
    equiv_harness_ctrl_if.master bus
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_RUN   = 2'd1;
    localparam logic [1:0]  S_DRAIN = 2'd2;
    localparam logic [1:0]  S_DONE  = 2'd3;
    // With no drain cycles configured the run finishes straight after RUN.
    localparam logic [1:0]  S_POST_RUN = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
    localparam logic [31:0] LFSR_MASK  = 32'h80200003;

    logic [1:0]        state_q, state_d;
    logic [31:0]       lfsr_q, lfsr_d, lfsr_nxt, seed_fix;
    logic [STIM_W-1:0] stim_q, stim_d;
    logic [15:0]       cycles_q, cycles_d;
    logic [16:0]       idx_q, idx_d;
    logic [15:0]       mc_q, mc_d;
    logic [15:0]       fc_q, fc_d;
    logic [8:0]        fb_q, fb_d;
    logic              pass_q, pass_d;
    logic [Y_W-1:0]    diff;
    logic              compare_en, run_last, drain_last;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_MASK) : (l >> 1);
    endfunction

    function automatic logic [STIM_W-1:0] stim_of(input logic [31:0] l);
        logic [62:0] full;
        full = {l[30:0], l};
        return STIM_W'(full);
    endfunction

    function automatic logic [8:0] lowest_bit(input logic [Y_W-1:0] v);
        logic [8:0] b;
        b = '0;
        for (int i = Y_W - 1; i >= 0; i--) begin
            if (v[i]) b = 9'(i);
        end
        return b;
    endfunction

    assign diff       = bus.y_a ^ bus.y_b;
    assign compare_en = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign lfsr_nxt   = lfsr_step(lfsr_q);
    assign seed_fix   = (bus.seed == 32'd0) ? 32'h1 : bus.seed;
    // idx_q counts compare cycles; RUN owns indices 0..cycles-1, DRAIN the rest.
    assign run_last   = (32'(idx_q) + 32'd1) == 32'(cycles_q);
    assign drain_last = (32'(idx_q) + 32'd1) == (32'(cycles_q) + 32'(DRAIN_CYC));

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        stim_d   = stim_q;
        cycles_d = cycles_q;
        idx_d    = idx_q;
        mc_d     = mc_q;
        fc_d     = fc_q;
        fb_d     = fb_q;
        pass_d   = pass_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    lfsr_d   = seed_fix;
                    cycles_d = bus.cycles;
                    idx_d    = '0;
                    mc_d     = '0;
                    fc_d     = '0;
                    fb_d     = '0;
                    pass_d   = 1'b0;
                    if (bus.cycles != 16'd0) begin
                        state_d = S_RUN;
                        stim_d  = stim_of(seed_fix);
                    end else begin
                        state_d = S_POST_RUN;
                    end
                end
            end
            S_RUN: begin
                idx_d = idx_q + 17'd1;
                if (run_last) begin
                    state_d = S_POST_RUN;
                end else begin
                    lfsr_d = lfsr_nxt;
                    stim_d = stim_of(lfsr_nxt);
                end
            end
            S_DRAIN: begin
                idx_d = idx_q + 17'd1;
                if (drain_last) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (compare_en && (diff != '0)) begin
            if (mc_q == 16'd0) begin
                fc_d = idx_q[15:0];
                fb_d = lowest_bit(diff);
            end
            if (mc_q != 16'hFFFF) mc_d = mc_q + 16'd1;
        end

        // Verdict is taken on entry to DONE so it includes the final compare.
        if ((state_d == S_DONE) && (state_q != S_DONE)) pass_d = (mc_d == 16'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lfsr_q   <= 32'h1;
            stim_q   <= '0;
            cycles_q <= '0;
            idx_q    <= '0;
            mc_q     <= '0;
            fc_q     <= '0;
            fb_q     <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            stim_q   <= stim_d;
            cycles_q <= cycles_d;
            idx_q    <= idx_d;
            mc_q     <= mc_d;
            fc_q     <= fc_d;
            fb_q     <= fb_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.stim           = stim_q;
    assign bus.busy           = compare_en;
    assign bus.done           = (state_q == S_DONE);
    assign bus.pass           = pass_q;
    assign bus.mismatch_count = mc_q;
    assign bus.first_cycle    = fc_q;
    assign bus.first_bit      = fb_q;

endmodule

// File: doc/equiv_harness_ctrl.md
EQUIV_HARNESS_CTRL -- requirements
Module: equiv_harness_ctrl

Interface
REQ-001 Parameter Y_W, default 421: width of each compared design output vector.
REQ-002 Parameter STIM_W, default 63: stimulus width; the four design inputs concatenated (21+10+14+18).
REQ-003 Parameter DRAIN_CYC, default 2: compare cycles after stimulus stops, to flush registered state.
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 start  in  1  begin a run; sampled only in IDLE.
REQ-007 cycles  in  16  number of stimulus cycles; sampled with start.
REQ-008 seed  in  32  LFSR seed; sampled with start.
REQ-009 stim  out  STIM_W  stimulus driven to both design copies.
REQ-010 y_a  in  Y_W  output of design copy A (original).
REQ-011 y_b  in  Y_W  output of design copy B (synthesized).
REQ-012 busy  out  1  high in RUN and DRAIN.
REQ-013 done  out  1  one-cycle pulse at end of run.
REQ-014 pass  out  1  valid from the done pulse until the next accepted start; 1 = no mismatch.
REQ-015 mismatch_count  out  16  compare cycles with y_a != y_b; saturates at 16'hFFFF.
REQ-016 first_cycle  out  16  compare-cycle index of the first mismatch.
REQ-017 first_bit  out  9  lowest differing bit index at the first mismatch.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE + start: LFSR <= (seed==0 ? 32'h1 : seed); cycle index <= 0; mismatch_count, first_cycle and first_bit cleared; pass <= 0.
- Next state is RUN if cycles != 0, otherwise DRAIN.
REQ-020 LFSR SHALL be a 32-bit Galois right-shift LFSR with mask 32'h80200003 (x^32+x^22+x^2+x+1).
- It advances once per RUN cycle, after the first RUN cycle.
REQ-021 stim SHALL equal {lfsr[30:0], lfsr[31:0]} in RUN, so RUN cycle k presents the seed advanced k steps.
- stim is held at its last RUN value in DRAIN and DONE.
- stim is 0 after reset.
REQ-022 RUN SHALL last exactly `cycles` cycles, then go to DRAIN.
REQ-023 DRAIN SHALL last exactly DRAIN_CYC cycles, then go to DONE.
REQ-024 DONE SHALL last one cycle (done=1, pass=(mismatch_count==0)), then go to IDLE.
REQ-025 Compare: in every RUN and DRAIN cycle, y_a is compared with y_b in the same cycle.
- Compare-cycle index runs 0 .. cycles+DRAIN_CYC-1.
REQ-026 On a mismatch: mismatch_count increments, saturating.
- first_cycle and first_bit are written only when mismatch_count==0 before the increment.
- first_bit = lowest set bit of (y_a ^ y_b).
REQ-027 No comparison SHALL occur in IDLE or DONE; y differences in those states are ignored.
REQ-028 start SHALL be ignored while busy or in DONE.
REQ-029 busy SHALL be 1 in RUN and DRAIN and 0 otherwise; done and busy are never high together.
REQ-030 Result outputs SHALL hold their values from DONE until the next accepted start.
REQ-031 All outputs SHALL be registered; no combinational path from y_a, y_b or start to any output.

Reset
REQ-032 rst=1 SHALL force, on the next edge, state IDLE and the following values:
- stim=0, busy=0, done=0, pass=0.
- mismatch_count=0, first_cycle=0, first_bit=0.
- LFSR=32'h1.
REQ-033 rst SHALL take priority over start and over any in-progress run.
- A run interrupted by rst produces no done pulse.
- Outputs read the reset values in the cycle after rst is sampled high.

Verification
REQ-034 Equal designs: start, cycles=100, seed=32'hACE1, y_b=y_a.
- Required: busy high for 102 cycles, then done=1, pass=1, mismatch_count=0.
REQ-035 Single-bit fault: y_b=y_a except bit 37 inverted during compare cycles 10..12, cycles=20.
- Required: mismatch_count=3, first_cycle=10, first_bit=37, pass=0.
REQ-036 Zero cases: seed=0 -> first stim equals {31'h1, 32'h1}; cycles=0 -> RUN skipped, 2 DRAIN compares, then done.
REQ-037 Saturation: y_b=~y_a, cycles=16'hFFFF.
- Required: mismatch_count=16'hFFFF, first_cycle=0, first_bit=0.
REQ-038 Reset and start rules:
- rst asserted mid-RUN -> all outputs at reset values the next cycle, no done pulse.
- start pulsed while busy -> no effect on cycle count or results.
